hash160_block_streamer: RTL

- Host-side front end for the Hash160 core. Accepts one 512-bit message block over a valid/ready handshake.
- Pulses the core reset, then drives the core's byte-wide text input with the 0xAA start marker followed by the 64 message bytes on consecutive cycles.
- Waits for the core's done flag, captures the 160-bit answer and returns it over a valid/ready handshake.
- Sits between the system bus/DMA and the top-level hash core.

---
 rtl/hash160_pkg.sv | 18 +
 rtl/hash160_byte_shifter.sv | 35 +++
 rtl/hash160_block_streamer.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/hash160_pkg.sv
// Shared constants and FSM state type for the Hash160 host-side block streamer.
package hash160_pkg;

  localparam logic [7:0]  START_MARKER = 8'hAA;
  localparam int unsigned BLK_BYTES    = 64;
  localparam int unsigned BLK_W        = 8 * BLK_BYTES;
  localparam int unsigned DIGEST_W     = 160;

  typedef enum logic [2:0] {
    StIdle,
    StCrst,
    StStart,
    StData,
    StWait,
    StHold
  } state_e;

endpackage

// File: rtl/hash160_byte_shifter.sv
// Block-wide load/shift register that presents its most significant byte.
module hash160_byte_shifter #(
  parameter int unsigned Width = hash160_pkg::BLK_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic             shift_i,
  input  logic [Width-1:0] data_i,
  output logic [7:0]       top_byte_o
);

  logic [Width-1:0] sr_q;
  logic [Width-1:0] sr_d;

  always_comb begin
    sr_d = sr_q;
    if (load_i) begin
      sr_d = data_i;
    end else if (shift_i) begin
      sr_d = {sr_q[Width-9:0], 8'h00};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

  assign top_byte_o = sr_q[Width-1 -: 8];

endmodule

// File: rtl/hash160_block_streamer.sv
// Streams one message block into the Hash160 core and returns the captured digest.
module hash160_block_streamer #(
  parameter int unsigned BLK_BYTES      = hash160_pkg::BLK_BYTES,
  parameter int unsigned DIGEST_W       = hash160_pkg::DIGEST_W,
  parameter int unsigned TIMEOUT_CYCLES = 4095
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_blk_valid,
  input  logic [8*BLK_BYTES-1:0] i_blk,
  output logic                   o_blk_ready,
  output logic                   o_core_rst_n,
  output logic [7:0]             o_text,
  input  logic                   i_core_valid,
  input  logic [DIGEST_W-1:0]    i_core_answer,
  output logic [DIGEST_W-1:0]    o_digest,
  output logic                   o_digest_valid,
  input  logic                   i_digest_ready,
  output logic                   o_timeout,
  output logic                   o_busy
);

  import hash160_pkg::*;

  localparam int unsigned CntW = $clog2(BLK_BYTES);
  localparam int unsigned ToW  = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CntW-1:0] LastByte = CntW'(BLK_BYTES - 1);
  localparam logic [ToW-1:0]  ToLimit  = ToW'(TIMEOUT_CYCLES);

  state_e              state_q, state_d;
  logic                blk_ready_q, blk_ready_d;
  logic                core_rst_n_q, core_rst_n_d;
  logic [7:0]          text_q, text_d;
  logic [DIGEST_W-1:0] digest_q, digest_d;
  logic                digest_valid_q, digest_valid_d;
  logic                timeout_q, timeout_d;
  logic                busy_q, busy_d;
  logic [CntW-1:0]     byte_cnt_q, byte_cnt_d;
  logic [ToW-1:0]      to_cnt_q, to_cnt_d;
  logic [ToW-1:0]      to_next;
  logic                core_valid_prev_q;
  logic                core_edge;
  logic                sr_load;
  logic                sr_shift;
  logic [7:0]          sr_top;

  hash160_byte_shifter #(
    .Width (8 * BLK_BYTES)
  ) u_shifter (
    .clk        (clk),
    .rst        (rst),
    .load_i     (sr_load),
    .shift_i    (sr_shift),
    .data_i     (i_blk),
    .top_byte_o (sr_top)
  );

  // The previous level is tracked in every state so a done level that is
  // already high when WAIT is entered never looks like a fresh edge.
  assign core_edge = i_core_valid & ~core_valid_prev_q;
  assign to_next   = to_cnt_q + 1'b1;

  always_comb begin
    state_d        = state_q;
    blk_ready_d    = blk_ready_q;
    core_rst_n_d   = core_rst_n_q;
    text_d         = text_q;
    digest_d       = digest_q;
    digest_valid_d = digest_valid_q;
    timeout_d      = timeout_q;
    byte_cnt_d     = byte_cnt_q;
    to_cnt_d       = to_cnt_q;
    sr_load        = 1'b0;
    sr_shift       = 1'b0;

    case (state_q)
      StIdle: begin
        blk_ready_d  = 1'b1;
        core_rst_n_d = 1'b1;
        text_d       = 8'h00;
        if (i_blk_valid && blk_ready_q) begin
          sr_load      = 1'b1;
          timeout_d    = 1'b0;
          blk_ready_d  = 1'b0;
          core_rst_n_d = 1'b0;
          state_d      = StCrst;
        end
      end
      StCrst: begin
        core_rst_n_d = 1'b1;
        text_d       = START_MARKER;
        state_d      = StStart;
      end
      StStart: begin
        text_d     = sr_top;
        sr_shift   = 1'b1;
        byte_cnt_d = '0;
        state_d    = StData;
      end
      StData: begin
        // byte_cnt_q is the index of the byte currently on o_text.
        if (byte_cnt_q == LastByte) begin
          text_d   = 8'h00;
          to_cnt_d = '0;
          state_d  = StWait;
        end else begin
          text_d     = sr_top;
          sr_shift   = 1'b1;
          byte_cnt_d = byte_cnt_q + 1'b1;
        end
      end
      StWait: begin
        text_d = 8'h00;
        if (core_edge) begin
          digest_d       = i_core_answer;
          digest_valid_d = 1'b1;
          state_d        = StHold;
        end else if (to_next == ToLimit) begin
          timeout_d = 1'b1;
          state_d   = StIdle;
        end else begin
          to_cnt_d = to_next;
        end
      end
      StHold: begin
        if (i_digest_ready) begin
          digest_valid_d = 1'b0;
          state_d        = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q           <= StIdle;
      blk_ready_q       <= 1'b0;
      core_rst_n_q      <= 1'b0;
      text_q            <= 8'h00;
      digest_q          <= '0;
      digest_valid_q    <= 1'b0;
      timeout_q         <= 1'b0;
      busy_q            <= 1'b0;
      byte_cnt_q        <= '0;
      to_cnt_q          <= '0;
      core_valid_prev_q <= 1'b0;
    end else begin
      state_q           <= state_d;
      blk_ready_q       <= blk_ready_d;
      core_rst_n_q      <= core_rst_n_d;
      text_q            <= text_d;
      digest_q          <= digest_d;
      digest_valid_q    <= digest_valid_d;
      timeout_q         <= timeout_d;
      busy_q            <= busy_d;
      byte_cnt_q        <= byte_cnt_d;
      to_cnt_q          <= to_cnt_d;
      core_valid_prev_q <= i_core_valid;
    end
  end

  assign o_blk_ready    = blk_ready_q;
  assign o_core_rst_n   = core_rst_n_q;
  assign o_text         = text_q;
  assign o_digest       = digest_q;
  assign o_digest_valid = digest_valid_q;
  assign o_timeout      = timeout_q;
  assign o_busy         = busy_q;

endmodule
